// File: rtl/spi_pkg.sv
// Shared types for the SPI master arbiter: FSM states, latched SPI mode,
// and the id-width helper used by the top and the round-robin arbiter.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans req circularly starting at ptr and returns the
// first requester found as a one-hot grant plus its index. Purely
// combinational so it can be reused behind any registered pointer.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Circular priority scan starting at ptr; the first hit wins.
  always_comb begin
    int j;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin SPI master sharing one SCLK/MOSI/MISO bus between NREQ
// requesters, each with its own active-low select. One WIDTH-bit full-duplex
// word per grant, MSB first, any CPOL/CPHA mode latched at grant time.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | SCLK follows live CPOL; grant the next requester round-robin
// SETUP    | select asserted, SCLK at idle level, CLKDIV cycles
// SHIFT    | 2*WIDTH SCLK edges, one every CLKDIV cycles
// HOLD     | SCLK back at idle level, select still low, CLKDIV cycles
// DONE     | select released, rvalid pulse with rdata/rid
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int WIDTH  = 32,
  parameter int CLKDIV = 4
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic                    CPOL,
  input  logic                    CPHA,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        rdata,
  output logic                    rvalid,
  output logic [$clog2(NREQ)-1:0] rid,
  output logic                    busy,
  output logic                    SCLK,
  output logic                    MOSI,
  input  logic                    MISO,
  output logic [NREQ-1:0]         SS_N
);

  localparam int IDW  = id_width(NREQ);
  localparam int DIVW = $clog2(CLKDIV + 1);
  localparam int ECW  = $clog2(2 * WIDTH + 1);

  localparam logic [DIVW-1:0] DIV_RELOAD  = DIVW'(CLKDIV - 1);
  localparam logic [ECW-1:0]  EDGES_TOTAL = ECW'(2 * WIDTH);

  spi_state_e       state_q, state_d;
  spi_mode_t        mode_q, mode_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [DIVW-1:0]  div_q, div_d;
  logic [ECW-1:0]   edges_q, edges_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic [NREQ-1:0]  ss_n_q, ss_n_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic [IDW-1:0]   rid_q, rid_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [IDW-1:0]   arb_idx;
  logic             arb_valid;
  logic [WIDTH-1:0] word_sel;

  logic edge_now, lead_edge, last_edge, sample_now, advance_now;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IDW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Pick the transmit word belonging to the requester being granted.
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) word_sel = wdata[i*WIDTH +: WIDTH];
    end
  end

  // edges_q counts remaining edges, so an even count marks a leading edge.
  assign edge_now    = (state_q == ST_SHIFT) && (div_q == '0);
  assign lead_edge   = ~edges_q[0];
  assign last_edge   = (edges_q == ECW'(1));
  assign sample_now  = edge_now && (mode_q.cpha ? ~lead_edge : lead_edge);
  assign advance_now = edge_now && (mode_q.cpha ? lead_edge : (~lead_edge && ~last_edge));

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    div_d    = div_q;
    edges_d  = edges_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    ss_n_d   = ss_n_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rid_d    = rid_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_SETUP;
          mode_d  = '{cpol: CPOL, cpha: CPHA};
          id_d    = arb_idx;
          ptr_d   = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + IDW'(1);
          div_d   = DIV_RELOAD;
          sclk_d  = CPOL;
          ss_n_d  = ~arb_gnt;
          rx_d    = '0;
          // CPHA=0 must show the MSB before the first (sampling) edge;
          // CPHA=1 presents it on the first edge instead.
          if (CPHA) begin
            mosi_d = 1'b0;
            tx_d   = word_sel;
          end else begin
            mosi_d = word_sel[WIDTH-1];
            tx_d   = {word_sel[WIDTH-2:0], 1'b0};
          end
        end
      end

      ST_SETUP: begin
        if (div_q == '0) begin
          state_d = ST_SHIFT;
          div_d   = DIV_RELOAD;
          edges_d = EDGES_TOTAL;
        end else begin
          div_d = div_q - DIVW'(1);
        end
      end

      ST_SHIFT: begin
        if (edge_now) begin
          sclk_d = ~sclk_q;
          div_d  = DIV_RELOAD;
          if (sample_now) rx_d = {rx_q[WIDTH-2:0], MISO};
          if (advance_now) begin
            mosi_d = tx_q[WIDTH-1];
            tx_d   = {tx_q[WIDTH-2:0], 1'b0};
          end
          if (last_edge) state_d = ST_HOLD;
          else           edges_d = edges_q - ECW'(1);
        end else begin
          div_d = div_q - DIVW'(1);
        end
      end

      ST_HOLD: begin
        sclk_d = mode_q.cpol;
        if (div_q == '0) begin
          state_d  = ST_DONE;
          ss_n_d   = '1;
          mosi_d   = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = rx_q;
          rid_d    = id_q;
        end else begin
          div_d = div_q - DIVW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        ss_n_d  = '1;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; synchronous reset discards any partial word.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      mode_q   <= '0;
      id_q     <= '0;
      ptr_q    <= '0;
      div_q    <= '0;
      edges_q  <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      ss_n_q   <= '1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      div_q    <= div_d;
      edges_q  <= edges_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      ss_n_q   <= ss_n_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt    = ((state_q == ST_IDLE) && !RESET) ? arb_gnt : '0;
  assign SCLK   = (state_q == ST_IDLE) ? CPOL : sclk_q;
  assign MOSI   = mosi_q;
  assign SS_N   = ss_n_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rid    = rid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: a table of single transfers on an 8-bit,
// CLKDIV=2 instance checked against a behavioural SPI slave, plus directed
// sequences for round-robin order, mid-transfer reset and back-to-back
// transfers on a CLKDIV=1 instance.
module tb_spi_master_arbiter;

  logic        clk;
  logic        RESET;
  logic        CPOL, CPHA;

  logic [1:0]  req;
  logic [15:0] wdata;
  logic [1:0]  gnt;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [0:0]  rid;
  logic        busy, SCLK, MOSI, MISO;
  logic [1:0]  SS_N;

  logic [1:0]  req_b;
  logic [15:0] wdata_b;
  logic [1:0]  gnt_b;
  logic [7:0]  rdata_b;
  logic        rvalid_b;
  logic [0:0]  rid_b;
  logic        busy_b, SCLK_b, MOSI_b, MISO_b;
  logic [1:0]  SS_N_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // MISO source: 0 loopback, 1 tied low, 2 tied high, 3 bench slave
  int         mmode = 0;
  logic       act_cpha = 1'b0;
  logic [7:0] act_sword = 8'h00;

  // slave/monitor state, written only by the monitor process
  logic       slv_bit = 1'b0;
  logic [7:0] slv_tx = 8'h00;
  logic [7:0] slv_rx = 8'h00;
  int         edge_cnt = 0;
  int         ss_first = -1;
  int         ss_last = -1;
  int         multi_low = 0;
  logic       sclk_prev = 1'b0;
  logic       ss_was_low = 1'b0;

  typedef struct {
    int         idx;
    logic       cpol;
    logic       cpha;
    logic [7:0] word;
    int         mm;
    logic [7:0] sword;
    logic       flip;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];

  spi_master_arbiter #(.NREQ(2), .WIDTH(8), .CLKDIV(2)) dut_a (
    .clk(clk), .RESET(RESET), .CPOL(CPOL), .CPHA(CPHA),
    .req(req), .wdata(wdata), .gnt(gnt), .rdata(rdata), .rvalid(rvalid),
    .rid(rid), .busy(busy), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS_N(SS_N)
  );

  spi_master_arbiter #(.NREQ(2), .WIDTH(8), .CLKDIV(1)) dut_b (
    .clk(clk), .RESET(RESET), .CPOL(CPOL), .CPHA(CPHA),
    .req(req_b), .wdata(wdata_b), .gnt(gnt_b), .rdata(rdata_b), .rvalid(rvalid_b),
    .rid(rid_b), .busy(busy_b), .SCLK(SCLK_b), .MOSI(MOSI_b), .MISO(MISO_b), .SS_N(SS_N_b)
  );

  assign MISO   = (mmode == 0) ? MOSI : (mmode == 1) ? 1'b0 : (mmode == 2) ? 1'b1 : slv_bit;
  assign MISO_b = MOSI_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SPI slave model and bus monitor for dut_a, sampled mid-cycle.
  always @(negedge clk) begin
    if (~&SS_N) begin
      if (!ss_was_low) begin
        ss_first = cyc;
        edge_cnt = 0;
        slv_rx   = 8'h00;
        slv_tx   = act_sword;
        slv_bit  = act_cpha ? 1'b0 : act_sword[7];
      end
      ss_last = cyc;
      if (SCLK !== sclk_prev) begin
        edge_cnt++;
        if (((edge_cnt % 2) == 1) != act_cpha) begin
          slv_rx = {slv_rx[6:0], MOSI};
        end else if (act_cpha) begin
          slv_bit = slv_tx[7];
          slv_tx  = {slv_tx[6:0], 1'b0};
        end else begin
          slv_tx  = {slv_tx[6:0], 1'b0};
          slv_bit = slv_tx[7];
        end
      end
    end
    ss_was_low = ~&SS_N;
    sclk_prev  = SCLK;
    if ($countones(~SS_N) > 1)   multi_low++;
    if ($countones(~SS_N_b) > 1) multi_low++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Called just after a negedge; returns the grant seen and its cycle.
  task automatic wait_gnt(output logic [1:0] g, output int gc);
    g  = 2'b00;
    gc = -1;
    for (int k = 0; k < 80; k++) begin
      #1;
      if (gnt != 2'b00) begin
        g  = gnt;
        gc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rvalid(output logic got);
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (rvalid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic xfer(input vec_t v);
    logic [1:0] g;
    int         gc;
    logic       got;
    @(negedge clk);
    act_cpha  = v.cpha;
    act_sword = v.sword;
    mmode     = v.mm;
    CPOL      = v.cpol;
    CPHA      = v.cpha;
    wdata[v.idx*8 +: 8] = v.word;
    req[v.idx] = 1'b1;
    wait_gnt(g, gc);
    chk("gnt_onehot", {30'd0, g}, 32'd1 << v.idx);
    @(negedge clk);
    req[v.idx] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (v.flip && cyc == gc + 10) CPOL = ~v.cpol;
      if (rvalid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rvalid_seen", {31'd0, got}, 32'd1);
    chk("rvalid_latency", cyc - gc, 32'd37);
    chk("rdata", {24'd0, rdata}, {24'd0, v.exp});
    chk("rid", {31'd0, rid}, v.idx);
    chk("ss_first", ss_first, gc + 1);
    chk("ss_last", ss_last, gc + 36);
    chk("sclk_edges", edge_cnt, 32'd16);
    chk("mosi_word", {24'd0, slv_rx}, {24'd0, v.word});
    chk("sclk_done", {31'd0, SCLK}, {31'd0, v.cpol});
    chk("busy_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("sclk_idle", {31'd0, SCLK}, v.flip ? {31'd0, ~v.cpol} : {31'd0, v.cpol});
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("rvalid_pulse", {31'd0, rvalid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rdata_hold", {24'd0, rdata}, {24'd0, v.exp});
  endtask

  initial begin
    logic [1:0] g;
    int         gc;
    logic       got;
    int         nrv;
    int         hr;

    //         idx cpol  cpha  word   mm sword  flip  exp
    vecs[0] = '{0, 1'b0, 1'b0, 8'hA5, 0, 8'h00, 1'b0, 8'hA5};
    vecs[1] = '{1, 1'b1, 1'b1, 8'h3C, 2, 8'h00, 1'b0, 8'hFF};
    vecs[2] = '{0, 1'b0, 1'b1, 8'h5A, 3, 8'hC3, 1'b0, 8'hC3};
    vecs[3] = '{1, 1'b1, 1'b0, 8'h81, 3, 8'h7E, 1'b0, 8'h7E};
    vecs[4] = '{0, 1'b0, 1'b0, 8'hFF, 1, 8'h00, 1'b0, 8'h00};
    vecs[5] = '{1, 1'b0, 1'b0, 8'h96, 0, 8'h00, 1'b1, 8'h96};

    RESET = 1'b1;
    CPOL = 1'b0; CPHA = 1'b0;
    req = 2'b00; wdata = '0;
    req_b = 2'b00; wdata_b = '0;
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    @(negedge clk);

    // reset values
    chk("rst_ss_n", {30'd0, SS_N}, 32'd3);
    chk("rst_mosi", {31'd0, MOSI}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rid", {31'd0, rid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_ss_n_b", {30'd0, SS_N_b}, 32'd3);
    CPOL = 1'b1; #1;
    chk("idle_sclk_hi", {31'd0, SCLK}, 32'd1);
    CPOL = 1'b0; #1;
    chk("idle_sclk_lo", {31'd0, SCLK}, 32'd0);

    // single transfers, all modes
    for (int i = 0; i < 6; i++) xfer(vecs[i]);

    // round-robin order with wrap: 0, 1, 0
    @(negedge clk);
    CPOL = 1'b0; CPHA = 1'b0; mmode = 0;
    wdata = {8'hB2, 8'h4D};
    req = 2'b11;
    wait_gnt(g, gc);
    chk("rr_first", {30'd0, g}, 32'd1);
    @(negedge clk);
    chk("gnt_one_cycle", {30'd0, gnt}, 32'd0);
    req[0] = 1'b0;
    wait_gnt(g, gc);
    chk("rr_second", {30'd0, g}, 32'd2);
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    req = 2'b11;
    wait_gnt(g, gc);
    chk("rr_wrap", {30'd0, g}, 32'd1);
    @(negedge clk);
    req = 2'b00;
    wait_rvalid(got);
    chk("rr_wrap_rvalid", {31'd0, got}, 32'd1);
    chk("rr_wrap_rid", {31'd0, rid}, 32'd0);
    chk("rr_wrap_rdata", {24'd0, rdata}, 32'h4D);

    // reset in the middle of SHIFT
    @(negedge clk);
    CPOL = 1'b1; CPHA = 1'b0; mmode = 0;
    wdata = {8'h11, 8'h55};
    req = 2'b01;
    wait_gnt(g, gc);
    chk("mid_rst_gnt", {30'd0, g}, 32'd1);
    @(negedge clk);
    req = 2'b00;
    repeat (8) @(negedge clk);
    chk("mid_rst_busy_before", {31'd0, busy}, 32'd1);
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    chk("mid_rst_ss_n", {30'd0, SS_N}, 32'd3);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_sclk", {31'd0, SCLK}, 32'd1);
    chk("mid_rst_mosi", {31'd0, MOSI}, 32'd0);
    nrv = 0;
    repeat (45) begin
      if (rvalid) nrv++;
      @(negedge clk);
    end
    chk("mid_rst_no_rvalid", nrv, 32'd0);
    req = 2'b11;
    wait_gnt(g, gc);
    chk("mid_rst_ptr_zero", {30'd0, g}, 32'd1);
    @(negedge clk);
    req = 2'b00;
    wait_rvalid(got);
    chk("post_rst_rvalid", {31'd0, got}, 32'd1);
    chk("post_rst_rdata", {24'd0, rdata}, 32'h55);

    // back-to-back transfers on requester 1, CLKDIV=1
    @(negedge clk);
    CPOL = 1'b0; CPHA = 1'b0;
    wdata_b = {8'hC9, 8'h00};
    req_b = 2'b10;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (SS_N_b[1] == 1'b0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("b2b_ss_low", {31'd0, got}, 32'd1);
    nrv = 0;
    hr  = 0;
    for (int k = 0; k < 60; k++) begin
      if (rvalid_b) begin
        nrv++;
        chk("b2b_rdata", {24'd0, rdata_b}, 32'hC9);
        chk("b2b_rid", {31'd0, rid_b}, 32'd1);
      end
      if (SS_N_b[1]) begin
        hr++;
      end else if (hr != 0) begin
        chk("b2b_gap", hr, 32'd2);
        hr = 0;
      end
      @(negedge clk);
    end
    chk("b2b_rvalid_count", nrv, 32'd3);
    req_b = 2'b00;
    repeat (30) @(negedge clk);
    chk("b2b_idle_busy", {31'd0, busy_b}, 32'd0);

    chk("one_ss_low", multi_low, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
